// File: rtl/l1mtx_arb_pkg.sv
// Shared encodings, FSM state type and burst-length helper for the L1 matrix
// output-stage arbiter.
package l1mtx_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [2:0] {
        ST_NOPORT,
        ST_SINGLE,
        ST_BURST,
        ST_INCR,
        ST_LOCKED
    } arb_state_t;

    // Beats still owed after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/l1mtx_rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward, so the
// previous owner is always the lowest-priority candidate.
module l1mtx_rr_pick #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           last,
    output logic [1:0]           idx,
    output logic                 none
);

    logic [3:0]  req4;
    int unsigned p;

    assign req4 = 4'(req);

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        idx  = last;
        none = 1'b1;
        p    = 0;
        for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
            p = (32'(last) + k) % NUM_PORTS;
            if (req4[2'(p)]) begin
                idx  = 2'(p);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/l1mtx_burst_arb.sv
// Burst- and lock-aware round-robin arbiter for one L1 matrix output stage.
// Grants hold across fixed bursts and locked sequences; INCR bursts are capped.
module l1mtx_burst_arb
    import l1mtx_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned INCR_LIMIT = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [1:0]           addr_in_port,
    output logic                 no_port,
    output logic                 grant_chg
);

    arb_state_t st;
    arb_state_t st_hold;
    logic [3:0] beats_left;
    logic [3:0] beats_nxt;
    logic [7:0] incr_cnt;
    logic [7:0] incr_nxt;
    logic       rearb;
    logic       nonseq;
    logic [1:0] pick_idx;
    logic       pick_none;

    l1mtx_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req  (req_port),
        .last (addr_in_port),
        .idx  (pick_idx),
        .none (pick_none)
    );

    // Decide whether this address-phase boundary holds the grant or re-arbitrates.
    always_comb begin
        rearb     = 1'b1;
        st_hold   = st;
        beats_nxt = beats_left;
        incr_nxt  = incr_cnt;
        nonseq    = HSELM && (HTRANSM == HTRANS_NONSEQ);
        if (no_port) begin
            rearb = 1'b1;
        end else if (HMASTLOCKM) begin
            rearb   = 1'b0;
            st_hold = ST_LOCKED;
        end else if (nonseq && (burst_beats(HBURSTM) != 4'd0)) begin
            rearb     = 1'b0;
            st_hold   = ST_BURST;
            beats_nxt = burst_beats(HBURSTM);
            incr_nxt  = 8'd0;
        end else if (nonseq && (HBURSTM == HBURST_INCR)) begin
            rearb     = (INCR_LIMIT <= 1);
            st_hold   = ST_INCR;
            beats_nxt = 4'd0;
            incr_nxt  = 8'd1;
        end else if ((st == ST_BURST) && (HTRANSM == HTRANS_BUSY)) begin
            rearb = 1'b0;
        end else if ((st == ST_BURST) && (HTRANSM == HTRANS_SEQ) && (beats_left > 4'd1)) begin
            rearb     = 1'b0;
            beats_nxt = beats_left - 4'd1;
        end else if ((st == ST_INCR) && (HTRANSM == HTRANS_BUSY)) begin
            rearb = 1'b0;
        end else if ((st == ST_INCR) && (HTRANSM == HTRANS_SEQ)) begin
            incr_nxt = incr_cnt + 8'd1;
            rearb    = ((32'(incr_cnt) + 32'd1) >= INCR_LIMIT);
        end
    end

    // State, counters and registered outputs; everything frozen while HREADYM is low.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            st           <= ST_NOPORT;
            beats_left   <= 4'd0;
            incr_cnt     <= 8'd0;
            addr_in_port <= 2'd0;
            no_port      <= 1'b1;
            grant_chg    <= 1'b0;
        end else if (HREADYM) begin
            if (rearb) begin
                beats_left <= 4'd0;
                incr_cnt   <= 8'd0;
                if (pick_none) begin
                    st        <= ST_NOPORT;
                    no_port   <= 1'b1;
                    grant_chg <= !no_port;
                end else begin
                    st           <= ST_SINGLE;
                    addr_in_port <= pick_idx;
                    no_port      <= 1'b0;
                    grant_chg    <= no_port || (pick_idx != addr_in_port);
                end
            end else begin
                st         <= st_hold;
                beats_left <= beats_nxt;
                incr_cnt   <= incr_nxt;
                grant_chg  <= 1'b0;
            end
        end else begin
            grant_chg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l1mtx_burst_arb.sv
// Directed bench for l1mtx_burst_arb: round-robin order, fixed and INCR bursts,
// wait states, lock hold, idle and asynchronous reset.
module tb_l1mtx_burst_arb;
    import l1mtx_arb_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] addr_in_port;
    logic       no_port;
    logic       grant_chg;

    int n_checks = 0;
    int n_errs   = 0;

    l1mtx_burst_arb #(.NUM_PORTS(4), .INCR_LIMIT(4)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .grant_chg    (grant_chg)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic [2:0] hb);
        HTRANSM = tr;
        HBURSTM = hb;
    endtask

    // Advance one edge, then check grant index, no_port and grant_chg.
    task automatic step_chk(input string tag, input logic [1:0] ea, input logic en, input logic eg);
        step();
        chk({tag, ".addr"}, 8'(addr_in_port), 8'(ea));
        chk({tag, ".np"},   8'(no_port),      8'(en));
        chk({tag, ".gchg"}, 8'(grant_chg),    8'(eg));
    endtask

    initial begin
        HRESET     = 1'b1;
        req_port   = 4'b0000;
        HREADYM    = 1'b1;
        HSELM      = 1'b1;
        HMASTLOCKM = 1'b0;
        drive(HTRANS_IDLE, HBURST_SINGLE);
        repeat (2) step();
        chk("rst.addr", 8'(addr_in_port), 8'd0);
        chk("rst.np",   8'(no_port),      8'd1);
        chk("rst.gchg", 8'(grant_chg),    8'd0);
        HRESET = 1'b0;

        // Round-robin with all four requesting single transfers.
        req_port = 4'b1111;
        drive(HTRANS_NONSEQ, HBURST_SINGLE);
        step_chk("rr1", 2'd1, 1'b0, 1'b1);
        step_chk("rr2", 2'd2, 1'b0, 1'b1);
        step_chk("rr3", 2'd3, 1'b0, 1'b1);
        step_chk("rr4", 2'd0, 1'b0, 1'b1);
        step_chk("rr5", 2'd1, 1'b0, 1'b1);

        // INCR4 from port 2 while port 3 waits.
        req_port = 4'b1100;
        step_chk("b.grant2", 2'd2, 1'b0, 1'b1);
        drive(HTRANS_NONSEQ, HBURST_INCR4);
        step_chk("b.beat1", 2'd2, 1'b0, 1'b0);
        drive(HTRANS_SEQ, HBURST_INCR4);
        step_chk("b.beat2", 2'd2, 1'b0, 1'b0);
        step_chk("b.beat3", 2'd2, 1'b0, 1'b0);
        step_chk("b.beat4", 2'd3, 1'b0, 1'b1);

        // INCR4 from port 3 with one BUSY inserted: five beats.
        drive(HTRANS_NONSEQ, HBURST_INCR4);
        step_chk("bb.beat1", 2'd3, 1'b0, 1'b0);
        drive(HTRANS_SEQ, HBURST_INCR4);
        step_chk("bb.beat2", 2'd3, 1'b0, 1'b0);
        drive(HTRANS_BUSY, HBURST_INCR4);
        step_chk("bb.busy", 2'd3, 1'b0, 1'b0);
        drive(HTRANS_SEQ, HBURST_INCR4);
        step_chk("bb.beat4", 2'd3, 1'b0, 1'b0);
        step_chk("bb.beat5", 2'd2, 1'b0, 1'b1);

        // WRAP8 from port 2, two wait states on beat 2, IDLE after beat 3.
        drive(HTRANS_NONSEQ, HBURST_WRAP8);
        step_chk("w.beat1", 2'd2, 1'b0, 1'b0);
        chk("w.beats7", 8'(dut.beats_left), 8'd7);
        drive(HTRANS_SEQ, HBURST_WRAP8);
        HREADYM = 1'b0;
        req_port = 4'b1000;
        step_chk("w.wait1", 2'd2, 1'b0, 1'b0);
        step_chk("w.wait2", 2'd2, 1'b0, 1'b0);
        chk("w.beatsw", 8'(dut.beats_left), 8'd7);
        HREADYM = 1'b1;
        step_chk("w.beat2", 2'd2, 1'b0, 1'b0);
        chk("w.beats6", 8'(dut.beats_left), 8'd6);
        step_chk("w.beat3", 2'd2, 1'b0, 1'b0);
        drive(HTRANS_IDLE, HBURST_SINGLE);
        step_chk("w.idle", 2'd3, 1'b0, 1'b1);
        chk("w.beats0", 8'(dut.beats_left), 8'd0);

        // Locked sequence from port 1; its request drops midway.
        req_port = 4'b0010;
        drive(HTRANS_NONSEQ, HBURST_SINGLE);
        step_chk("l.grant1", 2'd1, 1'b0, 1'b1);
        req_port   = 4'b0111;
        HMASTLOCKM = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) req_port = 4'b0101;
            step_chk($sformatf("l.lock%0d", i), 2'd1, 1'b0, 1'b0);
        end
        HMASTLOCKM = 1'b0;
        drive(HTRANS_IDLE, HBURST_SINGLE);
        step_chk("l.unlock", 2'd2, 1'b0, 1'b1);

        // INCR capped at four beats, then everyone goes idle.
        req_port = 4'b0001;
        drive(HTRANS_NONSEQ, HBURST_SINGLE);
        step_chk("i.grant0", 2'd0, 1'b0, 1'b1);
        req_port = 4'b0011;
        drive(HTRANS_NONSEQ, HBURST_INCR);
        step_chk("i.beat1", 2'd0, 1'b0, 1'b0);
        drive(HTRANS_SEQ, HBURST_INCR);
        step_chk("i.beat2", 2'd0, 1'b0, 1'b0);
        step_chk("i.beat3", 2'd0, 1'b0, 1'b0);
        step_chk("i.beat4", 2'd1, 1'b0, 1'b1);
        req_port = 4'b0000;
        drive(HTRANS_IDLE, HBURST_SINGLE);
        step_chk("i.idle1", 2'd1, 1'b1, 1'b1);
        step_chk("i.idle2", 2'd1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of an INCR16 burst.
        req_port = 4'b0100;
        step_chk("r.grant2", 2'd2, 1'b0, 1'b1);
        drive(HTRANS_NONSEQ, HBURST_INCR16);
        step_chk("r.beat1", 2'd2, 1'b0, 1'b0);
        drive(HTRANS_SEQ, HBURST_INCR16);
        step_chk("r.beat2", 2'd2, 1'b0, 1'b0);
        chk("r.beats14", 8'(dut.beats_left), 8'd14);
        #2;
        HRESET = 1'b1;
        #1;
        chk("r.addr",  8'(addr_in_port),    8'd0);
        chk("r.np",    8'(no_port),         8'd1);
        chk("r.gchg",  8'(grant_chg),       8'd0);
        chk("r.beats", 8'(dut.beats_left),  8'd0);
        step();
        HRESET = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
        $finish;
    end

endmodule
